// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one registered-read RAM between the instruction-fetch port
// and the data port. Accesses are serialised (grant, issue, response), contention is
// resolved round-robin, and out-of-range addresses are trapped without touching the RAM.
module ram_port_arbiter #(
    parameter int unsigned ADDR_LIMIT  = 4096,
    parameter bit          INSTR_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction fetch port
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    // data port
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_writedata,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    // RAM side
    output logic [31:0] ram_address,
    output logic [3:0]  ram_byteenable,
    output logic        ram_read,
    output logic        ram_write,
    output logic [31:0] ram_writedata,
    input  logic [31:0] ram_readdata,
    // sticky out-of-range flag
    output logic        range_err
);

    typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

    localparam logic OwnerInstr = 1'b0;
    localparam logic OwnerData  = 1'b1;

    state_e      state_q, state_d;
    logic        owner_q, owner_d;
    logic        op_write_q, op_write_d;
    logic        in_range_q, in_range_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] ram_address_q, ram_address_d;
    logic [3:0]  ram_byteenable_q, ram_byteenable_d;
    logic        ram_read_q, ram_read_d;
    logic        ram_write_q, ram_write_d;
    logic [31:0] ram_writedata_q, ram_writedata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        range_err_q, range_err_d;

    logic        i_req;
    logic        d_req;
    logic        pick;
    logic [31:0] sel_addr;
    logic [3:0]  sel_be;
    logic [31:0] sel_wdata;
    logic        sel_write;
    logic        sel_in_range;
    logic        resp_read;
    logic [31:0] resp_data;
    logic        i_done_rd;
    logic        d_done_rd;

    assign i_req = i_read;
    assign d_req = d_read | d_write;

    // Choose the port to grant this cycle and select its request fields.
    always_comb begin
        pick = OwnerInstr;
        if (i_req && d_req) begin
            pick = (last_grant_q == OwnerData) ? OwnerInstr : OwnerData;
        end else if (d_req) begin
            pick = OwnerData;
        end
        if (pick == OwnerData) begin
            sel_addr  = d_address;
            sel_be    = d_byteenable;
            sel_wdata = d_writedata;
            sel_write = d_write;  // read+write together is treated as a write
        end else begin
            sel_addr  = i_address;
            sel_be    = 4'b1111;
            sel_wdata = '0;
            sel_write = 1'b0;
        end
        // 33-bit sum so addresses near 2^32 cannot wrap into range
        sel_in_range = ({1'b0, sel_addr} + 33'd3) < {1'b0, ADDR_LIMIT};
    end

    // Read response: RAM data arrives in RESP; out-of-range reads return zero.
    // A port that dropped its request before completion does not see the result.
    assign resp_read = (state_q == StResp) && !op_write_q;
    assign resp_data = in_range_q ? ram_readdata : '0;
    assign i_done_rd = resp_read && (owner_q == OwnerInstr) && i_read;
    assign d_done_rd = resp_read && (owner_q == OwnerData) && d_read;

    // Next-state, grant latching and registered RAM strobes.
    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        op_write_d       = op_write_q;
        in_range_d       = in_range_q;
        last_grant_d     = last_grant_q;
        ram_address_d    = ram_address_q;
        ram_byteenable_d = ram_byteenable_q;
        ram_writedata_d  = ram_writedata_q;
        ram_read_d       = 1'b0;
        ram_write_d      = 1'b0;
        i_rdata_d        = i_rdata_q;
        d_rdata_d        = d_rdata_q;
        range_err_d      = range_err_q;

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    owner_d          = pick;
                    last_grant_d     = pick;
                    op_write_d       = sel_write;
                    in_range_d       = sel_in_range;
                    ram_address_d    = sel_addr;
                    ram_byteenable_d = sel_be;
                    ram_writedata_d  = sel_wdata;
                    // strobes are registered so they appear during ISSUE
                    ram_read_d       = !sel_write && sel_in_range;
                    ram_write_d      = sel_write && sel_in_range;
                    range_err_d      = range_err_q | !sel_in_range;
                    state_d          = StIssue;
                end
            end
            StIssue: begin
                state_d = StResp;
            end
            StResp: begin
                state_d = StIdle;
                if (i_done_rd) i_rdata_d = resp_data;
                if (d_done_rd) d_rdata_d = resp_data;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= StIdle;
            owner_q          <= OwnerInstr;
            op_write_q       <= 1'b0;
            in_range_q       <= 1'b0;
            last_grant_q     <= INSTR_FIRST ? OwnerData : OwnerInstr;
            ram_address_q    <= '0;
            ram_byteenable_q <= '0;
            ram_read_q       <= 1'b0;
            ram_write_q      <= 1'b0;
            ram_writedata_q  <= '0;
            i_rdata_q        <= '0;
            d_rdata_q        <= '0;
            range_err_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            op_write_q       <= op_write_d;
            in_range_q       <= in_range_d;
            last_grant_q     <= last_grant_d;
            ram_address_q    <= ram_address_d;
            ram_byteenable_q <= ram_byteenable_d;
            ram_read_q       <= ram_read_d;
            ram_write_q      <= ram_write_d;
            ram_writedata_q  <= ram_writedata_d;
            i_rdata_q        <= i_rdata_d;
            d_rdata_q        <= d_rdata_d;
            range_err_q      <= range_err_d;
        end
    end

    assign i_waitrequest  = i_req && !((state_q == StResp) && (owner_q == OwnerInstr));
    assign d_waitrequest  = d_req && !((state_q == StResp) && (owner_q == OwnerData));
    assign i_readdata     = i_done_rd ? resp_data : i_rdata_q;
    assign d_readdata     = d_done_rd ? resp_data : d_rdata_q;
    assign ram_address    = ram_address_q;
    assign ram_byteenable = ram_byteenable_q;
    assign ram_read       = ram_read_q;
    assign ram_write      = ram_write_q;
    assign ram_writedata  = ram_writedata_q;
    assign range_err      = range_err_q;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single byte-addressed tiny RAM between the CPU instruction-fetch port (read-only) and the CPU data port (read/write with byteenable).
- Sits between the CPU core and the RAM model, which has a registered read: data is valid the cycle after read is sampled.
- Serialises accesses, round-robins when both ports contend, stalls each port via waitrequest, and traps out-of-range addresses.

Parameters:
- ADDR_LIMIT, 4096: RAM size in bytes. An access is in range iff address+3 < ADDR_LIMIT.
- INSTR_FIRST, 1: after reset, instruction port wins the first contended grant. 0 gives data port first.

Ports:
- clk  in  1  clock, all state updates on posedge
- rst_n  in  1  synchronous active-low reset
- i_address  in  32  instruction fetch byte address
- i_read  in  1  instruction read request, held until waitrequest low
- i_waitrequest  out  1  stall to instruction port
- i_readdata  out  32  fetched word, valid when i_read=1 and i_waitrequest=0
- d_address  in  32  data byte address
- d_read  in  1  data read request
- d_write  in  1  data write request
- d_byteenable  in  4  data byte lanes
- d_writedata  in  32  data write value
- d_waitrequest  out  1  stall to data port
- d_readdata  out  32  loaded word, valid when d_read=1 and d_waitrequest=0
- ram_address  out  32  registered
- ram_byteenable  out  4  registered
- ram_read  out  1  registered strobe
- ram_write  out  1  registered strobe
- ram_writedata  out  32  registered
- ram_readdata  in  32  RAM read data, valid one cycle after ram_read
- range_err  out  1  sticky, set by any out-of-range request

Behaviour:
- States: IDLE, ISSUE, RESP.
- Reset (rst_n=0 at posedge):
  - State goes to IDLE.
  - All ram_* outputs, i_readdata, d_readdata and range_err go to 0.
  - last_grant goes to data if INSTR_FIRST=1, else to instr.
  - A strobe already presented to the RAM in that cycle is not retracted. Its response is discarded.
- IDLE:
  - Request present means i_read, or d_read|d_write.
  - If only one port requests, that port is granted. If both request, grant goes to the port opposite last_grant.
  - On grant, latch owner, op, address and byteenable (4'b1111 for instr), plus writedata. Update last_grant, then go to ISSUE.
  - If d_read and d_write are both 1, the op is write. Either way it occupies one grant.
- ISSUE:
  - ram_* outputs are driven from the latched values for exactly one cycle.
  - If the address is out of range, ram_read and ram_write stay 0 and range_err is set.
  - Next state is RESP.
- RESP:
  - Owner's waitrequest is 0 for exactly this cycle.
  - For a read, the owner's readdata = ram_readdata, or 0 if out of range. The owner's readdata holds this value until its next completion.
  - ram_* strobes are 0. Next state is IDLE.
- Latency:
  - Uncontended access: request seen in cycle N, completes (waitrequest=0) in cycle N+2.
  - Back-to-back throughput: one access per 3 cycles.
  - Contended loser completes in cycle N+5.
- waitrequest:
  - waitrequest = request & ~(state==RESP & owner==port).
  - When a port is not requesting, its waitrequest is 0.
  - Combinational from state and the request inputs; no path from address or data.
- Request rules:
  - A requester must hold its request, address, byteenable and writedata stable while waitrequest=1.
  - The arbiter samples only in IDLE. Changes during ISSUE/RESP affect only the next grant.
  - A request dropped before completion is still completed internally, and its result is discarded.
- d_byteenable=0 is forwarded unchanged. The RAM then writes nothing, and the read still returns a word.
- range_err is cleared only by reset.

Test Plan:
- Reset, then i_read=1 with i_address=0x0 and RAM word 0x8C010004 → ram_read=1 in cycle 1; i_waitrequest=0 and i_readdata=0x8C010004 in cycle 2; ram strobes 0 in cycles 0 and 2.
- d_write=1, d_address=0x100, d_byteenable=4'b0001, d_writedata=0xAB → ram_write=1 for one cycle with the latched values; d_waitrequest low in cycle 2 only. A following d_read of 0x100 returns low byte 0xAB.
- i_read and d_read both held from reset (INSTR_FIRST=1) → instr completes in cycle 2, data in cycle 5, instr in cycle 8. Grants alternate; neither port starves.
- d_read=1 and d_write=1 together at 0x40 → a single write is issued, no read strobe, and one completion.
- d_read at 0xFFE (ADDR_LIMIT=4096) → no RAM strobe; d_readdata=0 with d_waitrequest=0 in cycle 2; range_err=1 and stays set across later good accesses until rst_n=0.
- rst_n=0 asserted during ISSUE of a data write → all outputs 0 and state IDLE the next cycle. A subsequent i_read completes normally in 3 cycles.
